otter_mmio_hub: RTL and testbench

Parametrised memory-mapped I/O hub between the Otter_MCU IOBUS and board peripherals. It replaces hand-written per-wrapper address cases with three pieces:
- a generic slot decoder with N input and N output channels;
- per-channel one-cycle write strobes, so write-enable outputs such as a framebuffer WE never stick high;
- a small interrupt controller with synchronisers, edge detection, pending/mask registers and write-1-to-clear, which drives the CPU `INTR` line.

---
 rtl/otter_mmio_hub.sv | 110 +++++++++++
 tb/tb_otter_mmio_hub.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub for the Otter IOBUS: slot decoder, strobed output registers and a
// small edge-triggered interrupt controller driving INTR.
module otter_mmio_hub #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter logic [31:0] STRIDE    = 32'h20,
  parameter int unsigned N_IN      = 4,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned N_IRQ     = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [31:0]            IOBUS_ADDR,
  input  logic [31:0]            IOBUS_OUT,
  input  logic                   IOBUS_WR,
  output logic [31:0]            IOBUS_IN,
  input  logic [N_IN*32-1:0]     IN_DATA,
  output logic [N_OUT*OUT_W-1:0] OUT_DATA,
  output logic [N_OUT-1:0]       OUT_STB,
  input  logic [N_IRQ-1:0]       IRQ_SRC,
  output logic                   INTR
);

  localparam int unsigned Shift    = $clog2(STRIDE);
  localparam int unsigned NumSlots = N_IN + N_OUT + 2;
  localparam logic [31:0] PendSlot = 32'(N_IN + N_OUT);
  localparam logic [31:0] MaskSlot = 32'(N_IN + N_OUT + 1);

  logic [31:0]            offset;
  logic [31:0]            slot;
  logic                   mapped;

  logic [N_OUT*OUT_W-1:0] out_q, out_d;
  logic [N_OUT-1:0]       stb_q, stb_d;
  logic [N_IRQ-1:0]       mask_q, mask_d;
  logic [N_IRQ-1:0]       pend_q, pend_d;
  logic [N_IRQ-1:0]       clr;
  logic [N_IRQ-1:0]       s1_q, s2_q, s3_q;
  logic                   intr_q, intr_d;

  // Addresses below BASE_ADDR wrap to a huge slot index and fall out of the map.
  assign offset = IOBUS_ADDR - BASE_ADDR;
  assign slot   = offset >> Shift;
  assign mapped = (offset[Shift-1:0] == '0) && (slot < 32'(NumSlots));

  always_comb begin
    IOBUS_IN = '0;
    if (mapped) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (slot == 32'(i)) IOBUS_IN = IN_DATA[32*i +: 32];
      end
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (slot == 32'(N_IN + j)) IOBUS_IN[OUT_W-1:0] = out_q[OUT_W*j +: OUT_W];
      end
      if (slot == PendSlot) IOBUS_IN[N_IRQ-1:0] = pend_q;
      if (slot == MaskSlot) IOBUS_IN[N_IRQ-1:0] = mask_q;
    end
  end

  always_comb begin
    out_d  = out_q;
    stb_d  = '0;
    mask_d = mask_q;
    clr    = '0;
    if (IOBUS_WR && mapped) begin
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (slot == 32'(N_IN + j)) begin
          out_d[OUT_W*j +: OUT_W] = IOBUS_OUT[OUT_W-1:0];
          stb_d[j]                = 1'b1;
        end
      end
      if (slot == MaskSlot) mask_d = IOBUS_OUT[N_IRQ-1:0];
      if (slot == PendSlot) clr    = IOBUS_OUT[N_IRQ-1:0];
    end
  end

  // A new edge is OR'd in after the clear so that it wins a same-cycle collision.
  assign pend_d = (pend_q & ~clr) | (s2_q & ~s3_q);
  assign intr_d = |(pend_q & mask_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q  <= '0;
      stb_q  <= '0;
      mask_q <= '0;
      pend_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      intr_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      stb_q  <= stb_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      s1_q   <= IRQ_SRC;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      intr_q <= intr_d;
    end
  end

  assign OUT_DATA = out_q;
  assign OUT_STB  = stb_q;
  assign INTR     = intr_q;

  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT;

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Directed bench for otter_mmio_hub: vector table for decode/read/write, hand sequences for
// strobes, interrupt timing, set/clear collision and asynchronous reset.
module tb_otter_mmio_hub;

  localparam logic [31:0] Base = 32'h1100_0000;

  logic         CLK;
  logic         RST_N;
  logic [31:0]  IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  logic         IOBUS_WR;
  logic [127:0] IN_DATA;
  logic [63:0]  OUT_DATA;
  logic [3:0]   OUT_STB;
  logic [1:0]   IRQ_SRC;
  logic         INTR;

  int n_tests = 0;
  int n_fail  = 0;

  otter_mmio_hub dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .IN_DATA   (IN_DATA),
    .OUT_DATA  (OUT_DATA),
    .OUT_STB   (OUT_STB),
    .IRQ_SRC   (IRQ_SRC),
    .INTR      (INTR)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [3:0]  exp_stb;
    logic [63:0] exp_out;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic wr, logic [31:0] off, logic [31:0] wdata,
                              logic [31:0] exp_rd, logic [3:0] exp_stb, logic [63:0] exp_out);
    vec_t v;
    v.wr = wr; v.addr = Base + off; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_stb = exp_stb; v.exp_out = exp_out;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] data);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = Base + off;
    #1;
    data = IOBUS_IN;
  endtask

  // Issues a single write that is sampled on the next edge; returns just after that edge.
  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    IOBUS_WR   = 1'b1;
    IOBUS_ADDR = Base + off;
    IOBUS_OUT  = data;
    step();
    IOBUS_WR   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;

    vecs[0]  = mk(0, 32'h000, 32'h0,         32'hDEAD_BEEF, 4'b0000, 64'h0);
    vecs[1]  = mk(0, 32'h004, 32'h0,         32'h0,         4'b0000, 64'h0);
    vecs[2]  = mk(0, 32'h020, 32'h0,         32'h0BAD_F00D, 4'b0000, 64'h0);
    vecs[3]  = mk(0, 32'h140, 32'h0,         32'h0,         4'b0000, 64'h0);
    vecs[4]  = mk(0, 32'hFFFF_FFE0, 32'h0,   32'h0,         4'b0000, 64'h0);
    vecs[5]  = mk(1, 32'h080, 32'h1234_ABCD, 32'h0,         4'b0001, 64'h0000_0000_0000_ABCD);
    vecs[6]  = mk(0, 32'h080, 32'h0,         32'h0000_ABCD, 4'b0000, 64'h0000_0000_0000_ABCD);
    vecs[7]  = mk(1, 32'h000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 4'b0000, 64'h0000_0000_0000_ABCD);
    vecs[8]  = mk(1, 32'h084, 32'h0000_5555, 32'h0,         4'b0000, 64'h0000_0000_0000_ABCD);
    vecs[9]  = mk(0, 32'h080, 32'h0,         32'h0000_ABCD, 4'b0000, 64'h0000_0000_0000_ABCD);
    vecs[10] = mk(1, 32'h0A0, 32'hFFFF_1111, 32'h0,         4'b0010, 64'h0000_0000_1111_ABCD);
    vecs[11] = mk(0, 32'h0A0, 32'h0,         32'h0000_1111, 4'b0000, 64'h0000_0000_1111_ABCD);
    vecs[12] = mk(1, 32'h120, 32'hFFFF_FFFD, 32'h0,         4'b0000, 64'h0000_0000_1111_ABCD);
    vecs[13] = mk(0, 32'h120, 32'h0,         32'h0000_0001, 4'b0000, 64'h0000_0000_1111_ABCD);
    vecs[14] = mk(1, 32'h120, 32'h0,         32'h0000_0001, 4'b0000, 64'h0000_0000_1111_ABCD);
    vecs[15] = mk(0, 32'h100, 32'h0,         32'h0,         4'b0000, 64'h0000_0000_1111_ABCD);

    RST_N      = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    IRQ_SRC    = '0;
    IN_DATA    = {32'h3333_3333, 32'h2222_2222, 32'h0BAD_F00D, 32'hDEAD_BEEF};
    repeat (3) @(posedge CLK);
    #5 RST_N = 1'b1;
    step();
    chk("reset_out_data", OUT_DATA, 64'h0);
    chk("reset_out_stb", {60'h0, OUT_STB}, 64'h0);
    chk("reset_intr", {63'h0, INTR}, 64'h0);

    for (int i = 0; i < 16; i++) begin
      IOBUS_WR   = vecs[i].wr;
      IOBUS_ADDR = vecs[i].addr;
      IOBUS_OUT  = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), {32'h0, IOBUS_IN}, {32'h0, vecs[i].exp_rd});
      step();
      chk($sformatf("vec%0d_stb", i), {60'h0, OUT_STB}, {60'h0, vecs[i].exp_stb});
      chk($sformatf("vec%0d_out", i), OUT_DATA, vecs[i].exp_out);
    end
    IOBUS_WR = 1'b0;

    // Back-to-back writes to output 3.
    IOBUS_WR   = 1'b1;
    IOBUS_ADDR = Base + 32'h0E0;
    for (int k = 1; k <= 3; k++) begin
      IOBUS_OUT = 32'(k) * 32'h0101_0101;
      step();
      chk($sformatf("b2b_stb%0d", k), {60'h0, OUT_STB}, 64'h8);
    end
    IOBUS_WR = 1'b0;
    chk("b2b_out3", {48'h0, OUT_DATA[63:48]}, 64'h0303);
    step();
    chk("b2b_stb_end", {60'h0, OUT_STB}, 64'h0);

    // Masked interrupt, then unmask and clear.
    wr(32'h120, 32'h1);
    IRQ_SRC = 2'b10;
    step();
    step();
    rd(32'h100, r);
    chk("irq1_pend_early", {32'h0, r}, 64'h0);
    step();
    rd(32'h100, r);
    chk("irq1_pend_set", {32'h0, r}, 64'h2);
    step();
    chk("irq1_masked_intr", {63'h0, INTR}, 64'h0);
    wr(32'h120, 32'h3);
    chk("unmask_intr_e", {63'h0, INTR}, 64'h0);
    step();
    chk("unmask_intr_e1", {63'h0, INTR}, 64'h1);
    wr(32'h100, 32'h2);
    rd(32'h100, r);
    chk("clr_pend", {32'h0, r}, 64'h0);
    chk("clr_intr_e", {63'h0, INTR}, 64'h1);
    step();
    chk("clr_intr_e1", {63'h0, INTR}, 64'h0);

    // Set and write-1-clear of PEND[0] on the same edge: set wins.
    IRQ_SRC = 2'b11;
    step();
    step();
    rd(32'h100, r);
    chk("coll_pend_before", {32'h0, r}, 64'h0);
    wr(32'h100, 32'h1);
    rd(32'h100, r);
    chk("coll_pend_after", {32'h0, r}, 64'h1);
    chk("coll_intr_e2", {63'h0, INTR}, 64'h0);
    step();
    chk("coll_intr_e3", {63'h0, INTR}, 64'h1);

    // Asynchronous reset mid-strobe with INTR high.
    wr(32'h080, 32'h7777);
    chk("pre_rst_stb", {60'h0, OUT_STB}, 64'h1);
    chk("pre_rst_intr", {63'h0, INTR}, 64'h1);
    #3 RST_N = 1'b0;
    #1;
    chk("rst_stb", {60'h0, OUT_STB}, 64'h0);
    chk("rst_out", OUT_DATA, 64'h0);
    chk("rst_intr", {63'h0, INTR}, 64'h0);
    rd(32'h100, r);
    chk("rst_pend", {32'h0, r}, 64'h0);
    rd(32'h120, r);
    chk("rst_mask", {32'h0, r}, 64'h0);

    // Sources held high through reset release give exactly one edge, on the third edge.
    #3 RST_N = 1'b1;
    step();
    step();
    rd(32'h100, r);
    chk("rel_pend_e2", {32'h0, r}, 64'h0);
    step();
    rd(32'h100, r);
    chk("rel_pend_e3", {32'h0, r}, 64'h3);
    wr(32'h100, 32'h3);
    repeat (3) step();
    rd(32'h100, r);
    chk("rel_single_edge", {32'h0, r}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
